// File: rtl/sa_row_drain.sv
// Captures a full systolic-array result matrix and streams it out one row per
// handshake, with the signed row maximum computed combinationally alongside.
module sa_row_drain #(
  parameter  int D_W   = 8,
  parameter  int SA_R  = 16,
  parameter  int SA_C  = 16,
  localparam int IDX_W = (SA_R > 1) ? $clog2(SA_R) : 1
) (
  input  logic                                   I_CLK,
  input  logic                                   I_SYNC_RST,
  input  logic                                   I_MAT_VLD,
  input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]     I_MATRIX,
  input  logic                                   I_ROW_READY,
  output logic                                   O_ROW_VLD,
  output logic [0:SA_C-1][D_W-1:0]               O_ROW,
  output logic [IDX_W-1:0]                       O_ROW_IDX,
  output logic                                   O_ROW_LAST,
  output logic [D_W-1:0]                         O_ROW_MAX,
  output logic                                   O_BUSY,
  output logic                                   O_DROP
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SA_R - 1);

  state_t                             state, state_nxt;
  logic [IDX_W-1:0]                   row_cnt, row_cnt_nxt;
  logic                               drop_q, drop_nxt;
  logic [0:SA_R-1][0:SA_C-1][D_W-1:0] mat_buf;
  logic                               capture;
  logic                               xfer;
  logic                               at_last;
  logic signed [D_W-1:0]              row_max;

  assign xfer    = (state == DRAIN) && I_ROW_READY;
  assign at_last = (row_cnt == LAST_IDX);

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    drop_nxt    = drop_q;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (I_MAT_VLD) begin
          capture     = 1'b1;
          row_cnt_nxt = '0;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && at_last) begin
          // A new matrix arriving with the final handshake refills without a bubble.
          if (I_MAT_VLD) begin
            capture     = 1'b1;
            row_cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (xfer) begin
            row_cnt_nxt = row_cnt + 1'b1;
          end
          if (I_MAT_VLD) begin
            drop_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state   <= IDLE;
      row_cnt <= '0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      drop_q  <= drop_nxt;
    end
  end

  // Buffer holds data only; reset gating just keeps a reset-cycle capture from landing.
  always_ff @(posedge I_CLK) begin
    if (capture && !I_SYNC_RST) begin
      mat_buf <= I_MATRIX;
    end
  end

  always_comb begin
    row_max = O_ROW[0];
    for (int c = 1; c < SA_C; c++) begin
      if ($signed(O_ROW[c]) > row_max) begin
        row_max = O_ROW[c];
      end
    end
  end

  assign O_ROW      = mat_buf[row_cnt];
  assign O_ROW_IDX  = row_cnt;
  assign O_ROW_LAST = (state == DRAIN) && at_last;
  assign O_ROW_MAX  = row_max;
  assign O_ROW_VLD  = (state == DRAIN);
  assign O_BUSY     = (state == DRAIN);
  assign O_DROP     = drop_q;

endmodule

// File: tb/tb_sa_row_drain.sv
// Scoreboard bench for sa_row_drain: accepted matrices push their expected rows,
// the monitor checks every valid cycle against the queue head.
module tb_sa_row_drain;

  localparam int D_W  = 8;
  localparam int SA_R = 16;
  localparam int SA_C = 16;

  typedef logic [0:SA_R-1][0:SA_C-1][D_W-1:0] mat_t;
  typedef logic [0:SA_C-1][D_W-1:0]           row_t;

  typedef struct {
    row_t         row;
    int           idx;
    logic         last;
    logic [7:0]   mx;
  } exp_t;

  logic       clock;
  logic       I_SYNC_RST;
  logic       I_MAT_VLD;
  mat_t       I_MATRIX;
  logic       I_ROW_READY;
  logic       O_ROW_VLD;
  row_t       O_ROW;
  logic [3:0] O_ROW_IDX;
  logic       O_ROW_LAST;
  logic [7:0] O_ROW_MAX;
  logic       O_BUSY;
  logic       O_DROP;

  exp_t expQ[$];
  int   checks;
  int   errors;
  int   xferCount;

  sa_row_drain #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
    .I_CLK       (clock),
    .I_SYNC_RST  (I_SYNC_RST),
    .I_MAT_VLD   (I_MAT_VLD),
    .I_MATRIX    (I_MATRIX),
    .I_ROW_READY (I_ROW_READY),
    .O_ROW_VLD   (O_ROW_VLD),
    .O_ROW       (O_ROW),
    .O_ROW_IDX   (O_ROW_IDX),
    .O_ROW_LAST  (O_ROW_LAST),
    .O_ROW_MAX   (O_ROW_MAX),
    .O_BUSY      (O_BUSY),
    .O_DROP      (O_DROP)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] modelMax(input row_t r);
    logic signed [7:0] m;
    m = r[0];
    for (int c = 1; c < SA_C; c++) begin
      if ($signed(r[c]) > m) m = r[c];
    end
    return m;
  endfunction

  function automatic mat_t randomMatrix();
    mat_t m;
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++)
        m[r][c] = 8'($urandom_range(0, 255));
    return m;
  endfunction

  // Monitor compares every valid cycle, so a stall that changes outputs is caught too.
  always @(negedge clock) begin
    if (O_ROW_VLD) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_row", 1, 0);
      end else begin
        checkOutput("row",  O_ROW,      expQ[0].row);
        checkOutput("idx",  O_ROW_IDX,  expQ[0].idx);
        checkOutput("last", O_ROW_LAST, expQ[0].last);
        checkOutput("max",  O_ROW_MAX,  expQ[0].mx);
        if (I_ROW_READY) begin
          void'(expQ.pop_front());
          xferCount++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that samples the pulse.
  task automatic applyStimulus(input mat_t m, input bit expectAccept);
    exp_t e;
    I_MATRIX  = m;
    I_MAT_VLD = 1'b1;
    if (expectAccept) begin
      for (int r = 0; r < SA_R; r++) begin
        e.row  = m[r];
        e.idx  = r;
        e.last = (r == SA_R - 1);
        e.mx   = modelMax(m[r]);
        expQ.push_back(e);
      end
    end
    @(posedge clock); #1;
    I_MAT_VLD = 1'b0;
    I_MATRIX  = randomMatrix();
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      I_MATRIX = randomMatrix();
    end
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while ((expQ.size() != 0 || O_BUSY) && budget < 200) begin
      @(posedge clock); #2;
      budget++;
    end
    checkOutput("drain_timeout", budget < 200, 1);
  endtask

  mat_t m;
  int   pat[4] = '{1, 0, 0, 1};

  initial begin
    checks = 0; errors = 0; xferCount = 0;
    I_SYNC_RST = 1'b1; I_MAT_VLD = 1'b1; I_ROW_READY = 1'b1;
    I_MATRIX = randomMatrix();
    repeat (2) @(posedge clock);
    #1;
    I_SYNC_RST = 1'b0; I_MAT_VLD = 1'b0;
    checkOutput("rst_vld",  O_ROW_VLD,  0);
    checkOutput("rst_busy", O_BUSY,     0);
    checkOutput("rst_drop", O_DROP,     0);
    checkOutput("rst_idx",  O_ROW_IDX,  0);
    checkOutput("rst_last", O_ROW_LAST, 0);

    $display("[TB] basic drain");
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++)
        m[r][c] = 8'(c);
    xferCount = 0;
    applyStimulus(m, 1'b1);
    checkOutput("first_row_latency", O_ROW_VLD, 1);
    waitDrain();
    checkOutput("basic_xfers", xferCount, 16);
    checkOutput("basic_busy",  O_BUSY,    0);

    $display("[TB] signed max");
    m = randomMatrix();
    m[0][0] = 8'h80; m[0][1] = 8'hff; m[0][2] = 8'h7f;
    for (int c = 3; c < SA_C; c++) m[0][c] = 8'h00;
    for (int c = 0; c < SA_C; c++) m[1][c] = 8'h80;
    applyStimulus(m, 1'b1);
    checkOutput("max_mixed", O_ROW_MAX, 8'h7f);
    stepCycles(1);
    checkOutput("max_all_min", O_ROW_MAX, 8'h80);
    waitDrain();

    $display("[TB] backpressure");
    xferCount = 0;
    applyStimulus(randomMatrix(), 1'b1);
    for (int i = 0; i < 200 && expQ.size() != 0; i++) begin
      I_ROW_READY = pat[i % 4][0];
      stepCycles(1);
    end
    I_ROW_READY = 1'b1;
    waitDrain();
    checkOutput("bp_xfers", xferCount, 16);

    $display("[TB] back-to-back");
    applyStimulus(randomMatrix(), 1'b1);
    stepCycles(15);
    checkOutput("b2b_at_last", O_ROW_LAST, 1);
    applyStimulus(randomMatrix(), 1'b1);
    checkOutput("b2b_vld", O_ROW_VLD, 1);
    checkOutput("b2b_idx", O_ROW_IDX, 0);
    waitDrain();
    checkOutput("b2b_drop", O_DROP, 0);

    $display("[TB] overflow");
    applyStimulus(randomMatrix(), 1'b1);
    stepCycles(5);
    applyStimulus(randomMatrix(), 1'b0);
    checkOutput("ovf_drop_set", O_DROP, 1);
    waitDrain();
    stepCycles(5);
    checkOutput("ovf_drop_held", O_DROP, 1);

    $display("[TB] mid-drain reset");
    applyStimulus(randomMatrix(), 1'b1);
    stepCycles(7);
    checkOutput("mr_at_row7", O_ROW_IDX, 7);
    I_SYNC_RST = 1'b1;
    @(posedge clock); #1;
    I_SYNC_RST = 1'b0;
    expQ.delete();
    checkOutput("mr_vld",  O_ROW_VLD, 0);
    checkOutput("mr_busy", O_BUSY,    0);
    checkOutput("mr_drop", O_DROP,    0);
    xferCount = 0;
    applyStimulus(randomMatrix(), 1'b1);
    checkOutput("mr_restart_idx", O_ROW_IDX, 0);
    waitDrain();
    checkOutput("mr_xfers", xferCount, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
